// File: rtl/instr_prefetch_pkg.sv
// Shared fetch-side types for the core.
// Widths here fix the layout of fetch_entry_t.
package instr_prefetch_pkg;

  localparam int PKG_ADDR_W  = 32;
  localparam int PKG_INSTR_W = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0]  pc;
    logic [PKG_INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_OFFSET,
    PC_REG,
    PC_HOLD
  } pc_mux_e;

  function automatic logic is_redirect(
    input pc_mux_e sel
  );
    return sel == PC_OFFSET;
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Fetch unit bus: memory req/gnt/rvalid side
// plus the Decode-facing valid/ready side.
interface instr_prefetch_if
  import instr_prefetch_pkg::*;
#(
  parameter int ADDR_W  = PKG_ADDR_W,
  parameter int INSTR_W = PKG_INSTR_W
);

  logic               instr_req_op;
  logic [ADDR_W-1:0]  instr_addr_op;
  logic               instr_gnt_ip;
  logic               instr_rvalid_ip;
  logic [INSTR_W-1:0] instr_rdata_ip;
  logic               redirect_ip;
  logic [ADDR_W-1:0]  redirect_addr_ip;
  logic               fetch_valid_op;
  logic               fetch_ready_ip;
  logic [INSTR_W-1:0] fetch_instr_op;
  logic [ADDR_W-1:0]  fetch_pc_op;
  logic [ADDR_W-1:0]  fetch_next_pc_op;

  modport master (
    output instr_req_op,
    output instr_addr_op,
    input  instr_gnt_ip,
    input  instr_rvalid_ip,
    input  instr_rdata_ip,
    input  redirect_ip,
    input  redirect_addr_ip,
    output fetch_valid_op,
    input  fetch_ready_ip,
    output fetch_instr_op,
    output fetch_pc_op,
    output fetch_next_pc_op
  );

  modport slave (
    input  instr_req_op,
    input  instr_addr_op,
    output instr_gnt_ip,
    output instr_rvalid_ip,
    output instr_rdata_ip,
    output redirect_ip,
    output redirect_addr_ip,
    input  fetch_valid_op,
    output fetch_ready_ip,
    input  fetch_instr_op,
    input  fetch_pc_op,
    input  fetch_next_pc_op
  );

endinterface

// File: rtl/instr_prefetch_fetch_fifo.sv
// In-order FIFO of fetch entries with a
// registered head; flush empties it in one cycle.
module instr_prefetch_fetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_en;
  logic          push_en;

  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (reset) head <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_en)
                     - CW'(pop_en);
      // head tracks whichever entry is next
      if (pop_en && count > CW'(1))
        head <= mem[rd_ptr + 1'b1];
      else if (push_en && (empty || pop_en))
        head <= push_data;
    end
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (reset)
    !(push && full && !pop && !flush)
  );

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: credit-limited issue,
// in-order responses, redirect with stale drop.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int ADDR_W  = PKG_ADDR_W,
  parameter int INSTR_W = PKG_INSTR_W,
  parameter int DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic              clock,
  input logic              reset,
  instr_prefetch_if.master bus
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = CW + 1;

  logic               req_q;
  logic               stale_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      discard;

  logic               redirect;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  pc_base;
  logic [INSTR_W-1:0] rdata;
  logic               gnt;
  logic               rsp;
  logic               accept;
  logic               pop;
  logic               pend_after;
  logic               can_issue;
  logic [CW-1:0]      out_next;
  logic [CW-1:0]      fq_next;
  logic [SW-1:0]      credit;

  fetch_entry_t       aq_in;
  fetch_entry_t       aq_head;
  fetch_entry_t       fq_in;
  fetch_entry_t       fq_head;
  logic               aq_full;
  logic               aq_empty;
  logic [CW-1:0]      aq_cnt;
  logic               fq_full;
  logic               fq_empty;
  logic [CW-1:0]      fq_cnt;

  assign redirect = bus.redirect_ip;
  assign target   = {bus.redirect_addr_ip[ADDR_W-1:2],
                     2'b00};
  assign rdata    = bus.instr_rdata_ip;
  assign gnt      = req_q && bus.instr_gnt_ip;
  assign rsp      = bus.instr_rvalid_ip;
  assign accept   = rsp && discard == '0
                    && !redirect;
  assign pop      = bus.fetch_ready_ip
                    && !fq_empty && !redirect;

  assign out_next = outstanding + CW'(gnt)
                    - CW'(rsp);
  assign fq_next  = redirect ? '0
                    : fq_cnt + CW'(accept)
                      - CW'(pop);
  assign credit   = SW'(fq_next) + SW'(out_next);
  assign can_issue  = credit < SW'(DEPTH);
  assign pend_after = req_q && !bus.instr_gnt_ip;
  assign pc_base    = redirect ? target : fetch_pc;

  assign aq_in = '{pc: addr_q, instr: '0};
  assign fq_in = '{pc: aq_head.pc, instr: rdata};

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q       <= 1'b0;
      stale_q     <= 1'b0;
      addr_q      <= RESET_PC;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect)
        discard <= out_next;
      else
        discard <= discard
          - CW'(rsp && discard != '0)
          + CW'(gnt && stale_q);
      // an ungranted request keeps its address;
      // after a redirect its data is stale
      if (pend_after) begin
        stale_q  <= stale_q || redirect;
        fetch_pc <= pc_base;
      end else if (can_issue) begin
        req_q    <= 1'b1;
        stale_q  <= 1'b0;
        addr_q   <= pc_base;
        fetch_pc <= pc_base
                    + ADDR_W'(INSTR_BYTES);
      end else begin
        req_q    <= 1'b0;
        stale_q  <= 1'b0;
        fetch_pc <= pc_base;
      end
    end
  end

  instr_prefetch_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_addr_q (
    .clock     (clock),
    .reset     (reset),
    .push      (gnt && !stale_q && !redirect),
    .push_data (aq_in),
    .pop       (accept),
    .flush     (redirect),
    .head      (aq_head),
    .full      (aq_full),
    .empty     (aq_empty),
    .count     (aq_cnt)
  );

  instr_prefetch_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (fq_in),
    .pop       (pop),
    .flush     (redirect),
    .head      (fq_head),
    .full      (fq_full),
    .empty     (fq_empty),
    .count     (fq_cnt)
  );

  assign bus.instr_req_op     = req_q;
  assign bus.instr_addr_op    = addr_q;
  assign bus.fetch_valid_op   = !fq_empty;
  assign bus.fetch_instr_op   = fq_head.instr;
  assign bus.fetch_pc_op      = fq_head.pc;
  assign bus.fetch_next_pc_op = fq_head.pc
                                + ADDR_W'(INSTR_BYTES);

  a_rsp_has_addr: assert property (
    @(posedge clock) disable iff (reset)
    !(accept && aq_empty)
  );

  logic unused;
  assign unused = &{1'b0, aq_full, aq_cnt,
                    fq_full, aq_empty,
                    bus.redirect_addr_ip[1:0]};

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a
// simple in-order memory model per instance.
module tb_instr_prefetch;

  localparam logic [31:0] TAG = 32'hA5A5_0000;
  localparam int BIG = 32'h7fff_ffff;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
    int          cyc;
  } ent_t;

  logic clock;
  logic reset;

  instr_prefetch_if b0 ();
  instr_prefetch_if b1 ();

  instr_prefetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (b0)
  );

  instr_prefetch #(
    .DEPTH    (4),
    .RESET_PC (32'hFFFF_FFF8)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  bit          gnt_en;
  int          rsp_limit;
  int          hold_limit;
  logic [31:0] hold_addr;

  int          rsp_done;
  int          hold_done;
  int          cyc;
  logic [31:0] gq[$];
  logic [31:0] glog[$];
  ent_t        flog[$];
  logic [31:0] gq1[$];
  ent_t        flog1[$];

  // memory model 0: decides gnt/rvalid at negedge
  always @(negedge clock) begin
    bit g;
    cyc++;
    if (reset) begin
      gq.delete();
      glog.delete();
      flog.delete();
      rsp_done = 0;
      hold_done = 0;
      b0.instr_gnt_ip = 1'b0;
      b0.instr_rvalid_ip = 1'b0;
      b0.instr_rdata_ip = '0;
    end else begin
      if (rsp_done < rsp_limit && gq.size() > 0) begin
        b0.instr_rvalid_ip = 1'b1;
        b0.instr_rdata_ip = gq.pop_front() ^ TAG;
        rsp_done++;
      end else begin
        b0.instr_rvalid_ip = 1'b0;
      end
      g = 1'b0;
      if (b0.instr_req_op && gnt_en) begin
        if (b0.instr_addr_op == hold_addr
            && hold_done < hold_limit)
          hold_done++;
        else
          g = 1'b1;
      end
      b0.instr_gnt_ip = g;
      if (g) begin
        gq.push_back(b0.instr_addr_op);
        glog.push_back(b0.instr_addr_op);
      end
      if (b0.fetch_valid_op && b0.fetch_ready_ip
          && !b0.redirect_ip)
        flog.push_back('{pc: b0.fetch_pc_op,
                         instr: b0.fetch_instr_op,
                         npc: b0.fetch_next_pc_op,
                         cyc: cyc});
    end
  end

  // memory model 1: always grant, 1-cycle data
  always @(negedge clock) begin
    if (reset) begin
      gq1.delete();
      flog1.delete();
      b1.instr_gnt_ip = 1'b0;
      b1.instr_rvalid_ip = 1'b0;
      b1.instr_rdata_ip = '0;
    end else begin
      b1.instr_rvalid_ip = gq1.size() > 0;
      if (gq1.size() > 0)
        b1.instr_rdata_ip = gq1.pop_front() ^ TAG;
      b1.instr_gnt_ip = b1.instr_req_op;
      if (b1.instr_req_op)
        gq1.push_back(b1.instr_addr_op);
      if (b1.fetch_valid_op && b1.fetch_ready_ip
          && !b1.redirect_ip)
        flog1.push_back('{pc: b1.fetch_pc_op,
                          instr: b1.fetch_instr_op,
                          npc: b1.fetch_next_pc_op,
                          cyc: 0});
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int fidx;
    int gi;
    reset = 1'b1;
    gnt_en = 1'b1;
    rsp_limit = BIG;
    hold_limit = 0;
    hold_addr = '0;
    b0.fetch_ready_ip = 1'b1;
    b0.redirect_ip = 1'b0;
    b0.redirect_addr_ip = '0;
    b1.fetch_ready_ip = 1'b1;
    b1.redirect_ip = 1'b0;
    b1.redirect_addr_ip = '0;

    // reset state
    step(3);
    check("rst_req", b0.instr_req_op, 0);
    check("rst_addr", b0.instr_addr_op, 0);
    check("rst_valid", b0.fetch_valid_op, 0);
    check("rst_instr", b0.fetch_instr_op, 0);
    check("rst_pc", b0.fetch_pc_op, 0);
    check("rst_npc", b0.fetch_next_pc_op, 4);
    check("rst_addr1", b1.instr_addr_op,
          32'hFFFF_FFF8);

    // streaming
    reset = 1'b0;
    step(1);
    check("first_req", b0.instr_req_op, 1);
    check("first_addr", b0.instr_addr_op, 0);
    step(12);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_gnt%0d", i),
            glog[i], i * 4);
    check("t1_nlog", flog.size() >= 6, 1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_pc%0d", i),
            flog[i].pc, i * 4);
      check($sformatf("t1_instr%0d", i),
            flog[i].instr, (i * 4) ^ TAG);
      check($sformatf("t1_npc%0d", i),
            flog[i].npc, i * 4 + 4);
    end
    check("t1_thru", flog[5].cyc - flog[1].cyc, 4);
    check("wrap_pc0", flog1[0].pc, 32'hFFFF_FFF8);
    check("wrap_pc1", flog1[1].pc, 32'hFFFF_FFFC);
    check("wrap_npc1", flog1[1].npc, 0);
    check("wrap_pc2", flog1[2].pc, 0);
    check("wrap_instr2", flog1[2].instr, TAG);

    // decode stalled: credit limit
    reset = 1'b1;
    b0.fetch_ready_ip = 1'b0;
    step(2);
    reset = 1'b0;
    step(15);
    check("t2_ngnt", glog.size(), 4);
    check("t2_req", b0.instr_req_op, 0);
    check("t2_valid", b0.fetch_valid_op, 1);
    check("t2_pc", b0.fetch_pc_op, 0);
    b0.fetch_ready_ip = 1'b1;
    step(1);
    b0.fetch_ready_ip = 1'b0;
    step(8);
    check("t2_ngnt2", glog.size(), 5);
    check("t2_gnt4", glog[4], 32'h10);
    check("t2_req2", b0.instr_req_op, 0);
    check("t2_npop", flog.size(), 1);
    check("t2_pop", flog[0].pc, 0);

    // grant withheld three cycles at 0x8
    reset = 1'b1;
    b0.fetch_ready_ip = 1'b1;
    hold_addr = 32'h8;
    hold_limit = 3;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 20 && !(b0.instr_req_op
         && b0.instr_addr_op == 32'h8); i++)
      step(1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_req%0d", i),
            b0.instr_req_op, 1);
      check($sformatf("t3_addr%0d", i),
            b0.instr_addr_op, 32'h8);
      step(1);
    end
    check("t3_next", b0.instr_addr_op, 32'hC);
    check("t3_gnt8", glog[2], 32'h8);
    hold_limit = 0;

    // redirect with two responses outstanding
    reset = 1'b1;
    b0.fetch_ready_ip = 1'b0;
    rsp_limit = 0;
    step(2);
    reset = 1'b0;
    step(10);
    check("t4_ngnt", glog.size(), 4);
    check("t4_req0", b0.instr_req_op, 0);
    rsp_limit = 2;
    step(5);
    check("t4_valid", b0.fetch_valid_op, 1);
    check("t4_pc", b0.fetch_pc_op, 0);
    b0.redirect_ip = 1'b1;
    b0.redirect_addr_ip = 32'h103;
    step(1);
    b0.redirect_ip = 1'b0;
    check("t4_req", b0.instr_req_op, 1);
    check("t4_addr", b0.instr_addr_op, 32'h100);
    check("t4_flush", b0.fetch_valid_op, 0);
    rsp_limit = BIG;
    b0.fetch_ready_ip = 1'b1;
    step(12);
    check("t4_first", flog[0].pc, 32'h100);
    check("t4_data", flog[0].instr, 32'h100 ^ TAG);
    check("t4_second", flog[1].pc, 32'h104);

    // redirect while 0x20 is ungranted
    reset = 1'b1;
    hold_addr = 32'h20;
    hold_limit = 3;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 40 && !(b0.instr_req_op
         && b0.instr_addr_op == 32'h20); i++)
      step(1);
    b0.redirect_ip = 1'b1;
    b0.redirect_addr_ip = 32'h40;
    fidx = flog.size();
    gi = glog.size();
    step(1);
    b0.redirect_ip = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_req%0d", i),
            b0.instr_req_op, 1);
      check($sformatf("t5_hold%0d", i),
            b0.instr_addr_op, 32'h20);
      step(1);
    end
    check("t5_tgt", b0.instr_addr_op, 32'h40);
    check("t5_tgt_req", b0.instr_req_op, 1);
    step(12);
    check("t5_gnt_old", glog[gi], 32'h20);
    check("t5_gnt_new", glog[gi + 1], 32'h40);
    check("t5_first", flog[fidx].pc, 32'h40);
    check("t5_data", flog[fidx].instr,
          32'h40 ^ TAG);
    check("t5_second", flog[fidx + 1].pc, 32'h44);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
